// File: rtl/float_24_8_to_fixed_pkg.sv
// Shared float_24_8 types and helpers for the float -> fixed decode path.
// The rounding helper matches the adder's guard/sticky RNE rule.
package float_24_8_to_fixed_pkg;

  localparam int FLT_BIAS    = 127;
  localparam int FLT_MAN_W   = 23;
  localparam int FLT_EXP_MAX = 255;

  typedef struct packed {
    logic       sgn;
    logic [7:0] exp;
    logic [22:0] man;
  } float_24_8;

  function automatic logic rne_up(
    input logic lsb,
    input logic grd,
    input logic stk
  );
    return grd & (stk | lsb);
  endfunction

endpackage

// File: rtl/float_24_8_align.sv
// Stage-1 alignment: shifts the hidden-one mantissa onto the fixed grid,
// rounding to nearest even on right shifts and flagging left-shift overflow.
module float_24_8_align
  import float_24_8_to_fixed_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 16
) (
  input  float_24_8        in_data,
  output logic             sgn,
  output logic [OUT_W:0]   mag,
  output logic             ovf,
  output logic             isinf
);

  localparam int MW   = OUT_W + 1;
  localparam int WIDE = OUT_W + 25;
  localparam logic signed [9:0] OFFS =
    10'(FLT_BIAS + FLT_MAN_W - FRAC_W);
  localparam logic signed [9:0] DMAX = 10'(OUT_W);

  logic [23:0]        m;
  logic signed [9:0]  d;
  logic [5:0]         lsh;
  logic [5:0]         rsh;
  logic [WIDE-1:0]    wide;
  logic [49:0]        ext;
  logic [23:0]        kept;
  logic               grd;
  logic               stk;
  logic               up;

  always_comb begin
    m    = {1'b1, in_data.man};
    d    = signed'({2'b00, in_data.exp}) - OFFS;
    lsh  = 6'(d);
    rsh  = (d < -10'sd25) ? 6'd26 : 6'(-d);
    wide = WIDE'(m) << lsh;
    // 26 fraction bits below the kept field hold guard and sticky
    ext  = {m, 26'b0} >> rsh;
    kept = ext[49:26];
    grd  = ext[25];
    stk  = |ext[24:0];
    up   = rne_up(kept[0], grd, stk);

    sgn   = in_data.sgn;
    mag   = '0;
    ovf   = 1'b0;
    isinf = 1'b0;
    if (in_data.exp == 8'd0) begin
      sgn = 1'b0;
    end else if (in_data.exp == 8'(FLT_EXP_MAX)) begin
      isinf = 1'b1;
    end else if (d >= 10'sd0) begin
      ovf = (d >= DMAX) || (|wide[WIDE-1:MW]);
      mag = wide[OUT_W:0];
    end else begin
      mag = MW'(kept) + MW'(up);
    end
  end

endmodule

// File: rtl/float_24_8_to_fixed.sv
// float_24_8 -> signed fixed point, two-stage valid/ready pipeline:
// align/round, then sign apply and clamp.
module float_24_8_to_fixed
  import float_24_8_to_fixed_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  float_24_8        in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [OUT_W:0] POS_LIM =
    {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0] NEG_LIM =
    {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] POS_MAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MAX =
    {1'b1, {(OUT_W-1){1'b0}}};

  logic             a_sgn;
  logic [OUT_W:0]   a_mag;
  logic             a_ovf;
  logic             a_inf;

  logic             s1_valid;
  logic             s1_sgn;
  logic [OUT_W:0]   s1_mag;
  logic             s1_ovf;
  logic             s1_inf;

  logic             adv1;
  logic             adv2;
  logic             c_sat;
  logic [OUT_W-1:0] c_data;

  float_24_8_align #(
    .OUT_W  (OUT_W),
    .FRAC_W (FRAC_W)
  ) u_align (
    .in_data (in_data),
    .sgn     (a_sgn),
    .mag     (a_mag),
    .ovf     (a_ovf),
    .isinf   (a_inf)
  );

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  always_comb begin
    c_sat  = s1_ovf || s1_inf ||
             (s1_mag > (s1_sgn ? NEG_LIM : POS_LIM));
    c_data = s1_sgn ? OUT_W'(-s1_mag) : s1_mag[OUT_W-1:0];
    if (c_sat) begin
      c_data = s1_sgn ? NEG_MAX : POS_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) out_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        out_data <= c_data;
        out_sat  <= c_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_sgn <= a_sgn;
      s1_mag <= a_mag;
      s1_ovf <= a_ovf;
      s1_inf <= a_inf;
    end
  end

endmodule

// File: tb/tb_float_24_8_to_fixed.sv
// Bench for float_24_8_to_fixed (OUT_W=32, FRAC_W=16): real-arithmetic
// reference model, scoreboard queue, directed limits, backpressure, random.
module tb_float_24_8_to_fixed;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];
  logic        rnd_ready = 1'b0;

  always #5 clk = ~clk;

  float_24_8_to_fixed #(.OUT_W(32), .FRAC_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [31:0] mkf(input logic s, input int e, input int m);
    logic [31:0] f;
    f = {s, 8'(e), 23'(m)};
    return f;
  endfunction

  // value = 1.man * 2^(exp-127) scaled by 2^16, RNE to integer, clamp
  function automatic logic [32:0] model(input logic [31:0] f);
    logic sg;
    int e;
    int mn;
    real x, fl, fr;
    longint r, v;
    logic [63:0] vb;
    sg = f[31];
    e  = int'(f[30:23]);
    mn = int'(f[22:0]);
    if (e == 0) return 33'd0;
    if (e == 255) return sg ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
    x = (1.0 + real'(mn) / 8388608.0) * (2.0 ** (e - 127)) * 65536.0;
    if (x >= 17179869184.0) begin
      r = 64'sd17179869184;
    end else begin
      fl = $floor(x);
      fr = x - fl;
      r  = longint'(fl);
      if (fr > 0.5 || (fr == 0.5 && r[0])) r = r + 1;
    end
    v = sg ? -r : r;
    if (v > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
    if (v < -64'sd2147483648) return {1'b1, 32'h80000000};
    vb = v;
    return {1'b0, vb[31:0]};
  endfunction

  // scoreboard / stability monitor, sampled on the falling edge
  logic        held = 1'b0;
  logic [32:0] held_val;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        total++;
        if (!out_valid || {out_sat, out_data} !== held_val) begin
          bad++;
          $display("FAIL hold: got v=%0b %0b/%h want %0b/%h",
                   out_valid, out_sat, out_data, held_val[32], held_val[31:0]);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out: unexpected item %0b/%h", out_sat, out_data);
        end else begin
          held_val = exp_q.pop_front();
          if ({out_sat, out_data} !== held_val) begin
            bad++;
            $display("FAIL out: got %0b/%h want %0b/%h",
                     out_sat, out_data, held_val[32], held_val[31:0]);
          end
        end
      end
      held = out_valid && !out_ready;
      held_val = {out_sat, out_data};
    end
  end

  task automatic check(input string nm, input logic [32:0] got, input logic [32:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic push(input logic [31:0] f);
    int k;
    logic acc;
    k = 0;
    in_data = f;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      k++;
    end while (!acc && k < 200);
    in_valid = 1'b0;
    if (!acc) check("push_timeout", 33'd0, 33'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    check("drain", 33'(exp_q.size()), 33'd0);
  endtask

  logic [31:0] pin_f[10];
  logic [32:0] pin_e[10];

  initial begin
    int idx, nout, cnt;
    logic saw_low, acc;
    logic [31:0] vec[8];

    pin_f[0] = mkf(0, 127, 0);        pin_e[0] = {1'b0, 32'h00010000};
    pin_f[1] = mkf(1, 128, 'h200000); pin_e[1] = {1'b0, 32'hFFFD8000};
    pin_f[2] = mkf(0, 110, 0);        pin_e[2] = {1'b0, 32'h00000000};
    pin_f[3] = mkf(0, 110, 'h400000); pin_e[3] = {1'b0, 32'h00000001};
    pin_f[4] = mkf(0, 111, 'h400000); pin_e[4] = {1'b0, 32'h00000002};
    pin_f[5] = mkf(0, 147, 0);        pin_e[5] = {1'b1, 32'h7FFFFFFF};
    pin_f[6] = mkf(1, 142, 0);        pin_e[6] = {1'b0, 32'h80000000};
    pin_f[7] = mkf(1, 142, 1);        pin_e[7] = {1'b1, 32'h80000000};
    pin_f[8] = mkf(0, 255, 'h12345);  pin_e[8] = {1'b1, 32'h7FFFFFFF};
    pin_f[9] = mkf(1, 0, 'h7FFFFF);   pin_e[9] = {1'b0, 32'h00000000};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 33'(out_valid), 33'd0);
    check("rst_data", {out_sat, out_data}, 33'd0);
    check("rst_in_ready", 33'(in_ready), 33'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) check($sformatf("pin%0d", i), model(pin_f[i]), pin_e[i]);
    for (int i = 0; i < 10; i++) push(pin_f[i]);
    drain();

    // backpressure: 8 back-to-back, out_ready low in cycles 3..5
    for (int i = 0; i < 8; i++) vec[i] = mkf(i[0], 120 + 3 * i, 'h10101 * i);
    idx = 0;
    nout = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid = (idx < 8);
      in_data = vec[idx % 8];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready && c >= 6 && c <= 12) nout++;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_in_ready_low", 33'(saw_low), 33'd1);
    check("bp_throughput", 33'(nout), 33'd7);
    check("bp_all_sent", 33'(idx), 33'd8);
    drain();

    // reset with two items in flight
    out_ready = 1'b0;
    push(mkf(0, 130, 5));
    push(mkf(1, 131, 7));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 33'(out_valid), 33'd0);
    check("mid_rst_in_ready", 33'(in_ready), 33'd1);
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("mid_rst_no_stale", 33'(cnt), 33'd0);
    @(posedge clk);
    #1;

    // random stream with random downstream readiness
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      int sel, e;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) e = 0;
      else if (sel == 1) e = 255;
      else if (sel < 7) e = int'($urandom_range(100, 160));
      else e = int'($urandom_range(1, 254));
      push(mkf(1'($urandom_range(0, 1)), e, int'($urandom_range(0, 32'h7FFFFF))));
    end
    rnd_ready = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
